// File: rtl/insn_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package insn_pkg;

  localparam int PC_W   = 10;
  localparam int INSN_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  // Word index increment; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift-style FIFO of fetch entries; entry0 is always the head,
// so the head keeps its last value once the buffer drains.
module fetch_fifo
  import insn_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry0;
  fetch_entry_t entry1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      case (count)
        2'd0: begin
          if (push) entry0 <= din;
        end
        2'd1: begin
          if (push && pop)  entry0 <= din;
          else if (push)    entry1 <= din;
        end
        default: begin
          // Full: a push is only ever accompanied by a pop here.
          if (pop)  entry0 <= entry1;
          if (push) entry1 <= din;
        end
      endcase
    end
  end

  assign head = entry0;

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch: owns the PC, issues to insn_mem, buffers responses for decode.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module insn_fetch
  import insn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   pc_out,
  input  logic [INSN_W-1:0] insn_out,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [INSN_W-1:0] fetch_insn,
  output logic [PC_W-1:0]   fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  fetch_state_t    fetch_state;

  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      occupancy;

  assign fetch_valid = (count != 2'd0);
  // A redirect wins: the head presented alongside it is not consumed.
  assign pop         = fetch_valid & fetch_ready & ~redirect_valid;
  assign push        = inflight & ~redirect_valid;
  assign occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  // BOOT and FLUSH start from an empty pipe, so they always issue.
  assign issue       = ~redirect_valid & ((fetch_state != RUN) | (occupancy < 3'd2));

  assign push_entry.insn = insn_out;
  assign push_entry.pc   = inflight_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      inflight    <= 1'b0;
      fetch_state <= BOOT;
    end else begin
      if (redirect_valid) begin
        pc_reg   <= redirect_pc;
        inflight <= 1'b0;
      end else if (issue) begin
        pc_reg   <= next_pc(pc_reg);
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
      fetch_state <= redirect_valid ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= pc_reg;
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .count (count)
  );

  assign pc_out     = pc_reg;
  assign fetch_insn = head.insn;
  assign fetch_pc   = head.pc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue)                     perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (fetch_valid & ~fetch_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
